// File: rtl/rv32i_pkg.sv
// Shared opcode constants and flag-bundle type for the RV32I opcode-class decoder.
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_VR     = 7'b0001011;
    localparam logic [6:0] OP_S2V    = 7'b0101011;
    localparam logic [6:0] OP_V2S    = 7'b1011011;
    localparam logic [6:0] OP_VSTORE = 7'b0100111;
    localparam logic [6:0] OP_VLOAD  = 7'b0000111;
    localparam logic [6:0] OP_VABS   = 7'b1111011;

    typedef struct packed {
        logic r;
        logic i_arithmetic_logic;
        logic i_load;
        logic store;
        logic branch;
        logic jump;
        logic i_jump;
        logic u;
        logic u_pc;
        logic i_transfer;
        logic vector_r;
        logic scalar_to_vector;
        logic vector_to_scalar;
        logic store_vector;
        logic load_vector;
        logic vector_absolute;
    } dec_flags_t;

endpackage

// File: rtl/rv32i_opcode_lut.sv
// Combinational exact-match opcode to class-flag lookup.
// Vector classes decode only when VECTOR_EXT_EN is defined; otherwise they fall to no-match.
module rv32i_opcode_lut
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode,
    output dec_flags_t flags,
    output logic       hit
);

    always_comb begin
        flags = '0;
        unique case (opcode)
            OP_R:      flags.r                  = 1'b1;
            OP_IMM:    flags.i_arithmetic_logic = 1'b1;
            OP_LOAD:   flags.i_load             = 1'b1;
            OP_STORE:  flags.store              = 1'b1;
            OP_BRANCH: flags.branch             = 1'b1;
            OP_JAL:    flags.jump               = 1'b1;
            OP_JALR:   flags.i_jump             = 1'b1;
            OP_LUI:    flags.u                  = 1'b1;
            OP_AUIPC:  flags.u_pc               = 1'b1;
            OP_SYSTEM: flags.i_transfer         = 1'b1;
`ifdef VECTOR_EXT_EN
            OP_VR:     flags.vector_r           = 1'b1;
            OP_S2V:    flags.scalar_to_vector   = 1'b1;
            OP_V2S:    flags.vector_to_scalar   = 1'b1;
            OP_VSTORE: flags.store_vector       = 1'b1;
            OP_VLOAD:  flags.load_vector        = 1'b1;
            OP_VABS:   flags.vector_absolute    = 1'b1;
`endif
            default:   flags = '0;
        endcase
    end

    assign hit = |flags;

endmodule

// File: rtl/instruction_decoder_rv32i.sv
// Registered one-hot opcode-class decoder for RV32I plus custom vector ops.
// Vector decoding is enabled by defining VECTOR_EXT_EN.
module instruction_decoder_rv32i
    import rv32i_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    input  logic [6:0] opcode,
    output logic       dec_valid,
    output logic       r,
    output logic       i_arithmetic_logic,
    output logic       i_load,
    output logic       store,
    output logic       branch,
    output logic       jump,
    output logic       i_jump,
    output logic       u,
    output logic       u_pc,
    output logic       i_transfer,
    output logic       vector_r,
    output logic       scalar_to_vector,
    output logic       vector_to_scalar,
    output logic       store_vector,
    output logic       load_vector,
    output logic       vector_absolute,
    output logic       illegal
);

    dec_flags_t lut_flags;
    dec_flags_t flags_q;
    logic       lut_hit;
    logic       illegal_q;
    logic       valid_q;

    rv32i_opcode_lut u_lut (
        .opcode (opcode),
        .flags  (lut_flags),
        .hit    (lut_hit)
    );

    // Flags are gated by instr_valid before the register so an idle slot never looks decoded.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= instr_valid;
            flags_q   <= instr_valid ? lut_flags : '0;
            illegal_q <= instr_valid & ~lut_hit;
        end
    end

    assign dec_valid          = valid_q;
    assign illegal            = illegal_q;
    assign r                  = flags_q.r;
    assign i_arithmetic_logic = flags_q.i_arithmetic_logic;
    assign i_load             = flags_q.i_load;
    assign store              = flags_q.store;
    assign branch             = flags_q.branch;
    assign jump               = flags_q.jump;
    assign i_jump             = flags_q.i_jump;
    assign u                  = flags_q.u;
    assign u_pc               = flags_q.u_pc;
    assign i_transfer         = flags_q.i_transfer;
    assign vector_r           = flags_q.vector_r;
    assign scalar_to_vector   = flags_q.scalar_to_vector;
    assign vector_to_scalar   = flags_q.vector_to_scalar;
    assign store_vector       = flags_q.store_vector;
    assign load_vector        = flags_q.load_vector;
    assign vector_absolute    = flags_q.vector_absolute;

endmodule

// File: tb/tb_instruction_decoder_rv32i.sv
// Self-checking bench for instruction_decoder_rv32i; reference is an opcode table lookup.
module tb_instruction_decoder_rv32i;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic [6:0] opcode = '0;
    logic dec_valid, r, i_arithmetic_logic, i_load, store, branch, jump, i_jump, u, u_pc;
    logic i_transfer, vector_r, scalar_to_vector, vector_to_scalar, store_vector;
    logic load_vector, vector_absolute, illegal;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    instruction_decoder_rv32i dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
        .dec_valid(dec_valid), .r(r), .i_arithmetic_logic(i_arithmetic_logic),
        .i_load(i_load), .store(store), .branch(branch), .jump(jump), .i_jump(i_jump),
        .u(u), .u_pc(u_pc), .i_transfer(i_transfer), .vector_r(vector_r),
        .scalar_to_vector(scalar_to_vector), .vector_to_scalar(vector_to_scalar),
        .store_vector(store_vector), .load_vector(load_vector),
        .vector_absolute(vector_absolute), .illegal(illegal)
    );

    // Observed bundle: {dec_valid, illegal, 16 class flags in table order}
    logic [17:0] got;
    assign got = {dec_valid, illegal, r, i_arithmetic_logic, i_load, store, branch, jump,
                  i_jump, u, u_pc, i_transfer, vector_r, scalar_to_vector,
                  vector_to_scalar, store_vector, load_vector, vector_absolute};

    // Class opcodes in the same order as the flag bits above (MSB first); last six are vector.
    int class_op [16] = '{51, 19, 3, 35, 99, 111, 103, 55, 23, 115, 11, 43, 91, 39, 7, 123};

`ifdef VECTOR_EXT_EN
    localparam bit VEC_EN = 1'b1;
`else
    localparam bit VEC_EN = 1'b0;
`endif

    function automatic logic [17:0] model(input bit rs, input bit v, input int op);
        logic [17:0] e;
        e = '0;
        if (rs) return e;
        e[17] = v;
        if (!v) return e;
        e[16] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (class_op[i] == op && (i < 10 || VEC_EN)) begin
                e[15 - i] = 1'b1;
                e[16] = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic apply(input bit rs, input bit v, input int op);
        rst = rs;
        instr_valid = v;
        opcode = op[6:0];
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [17:0] exp;
        for (int k = 0; k < 2; k++) begin
            apply(1'b1, 1'b1, 51);
            exp = '0;
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset cycle %0d: got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_scalar();
        logic [17:0] exp;
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b1, class_op[i]);
            exp = model(1'b0, 1'b1, class_op[i]);
            vectors++;
            if (got !== exp || got[15 - i] !== 1'b1) begin
                errors++;
                $display("FAIL scalar op %0d: got %b expected %b", class_op[i], got, exp);
            end
        end
    endtask

    task automatic test_vector();
        logic [17:0] exp;
        for (int i = 10; i < 16; i++) begin
            apply(1'b0, 1'b1, class_op[i]);
            exp = model(1'b0, 1'b1, class_op[i]);
            vectors++;
            if (got !== exp || got[16] !== !VEC_EN || got[15 - i] !== VEC_EN) begin
                errors++;
                $display("FAIL vector op %0d: got %b expected %b", class_op[i], got, exp);
            end
        end
    endtask

    task automatic test_illegal();
        int ops [3] = '{0, 127, 50};
        logic [17:0] exp;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, ops[i]);
            exp = {2'b11, 16'h0000};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL illegal op %0d: got %b expected %b", ops[i], got, exp);
            end
        end
    endtask

    task automatic test_gating();
        logic [17:0] exp;
        apply(1'b0, 1'b0, 51);
        exp = '0;
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL gating op 51 invalid: got %b expected %b", got, exp);
        end
    endtask

    task automatic test_exhaustive();
        logic [17:0] exp;
        for (int op = 0; op < 128; op++) begin
            apply(1'b0, 1'b1, op);
            exp = model(1'b0, 1'b1, op);
            vectors++;
            if (got !== exp || $countones(got[16:0]) != 1) begin
                errors++;
                $display("FAIL exhaustive op %0d: got %b expected %b", op, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp;
        int op;
        bit v, rs;
        for (int k = 0; k < 300; k++) begin
            rs = ($urandom_range(0, 15) == 0);
            v  = ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 1) == 0) ? class_op[$urandom_range(0, 15)]
                                              : int'($urandom_range(0, 127));
            apply(rs, v, op);
            exp = model(rs, v, op);
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random rst=%0d v=%0d op=%0d: got %b expected %b",
                         rs, v, op, got, exp);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_scalar();
        test_vector();
        test_illegal();
        test_gating();
        test_exhaustive();
        test_back_to_back();
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
